// File: rtl/dcpu16_pkg.sv
// dcpu16_pkg: shared constants for the DCPU16 core.
// Opcodes, divider FSM encoding and iteration counts.
package dcpu16_pkg;

    localparam logic [3:0] OPC_DIV = 4'h5;
    localparam logic [3:0] OPC_MOD = 4'h6;

    localparam int DIV_ITER = 32;
    localparam int MOD_ITER = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic is_divop(input logic [3:0] opc);
        return (opc == OPC_DIV) || (opc == OPC_MOD);
    endfunction

endpackage

// File: rtl/dcpu16_divstep.sv
// dcpu16_divstep: one restoring shift-subtract step.
// 17-bit trial remainder keeps the compare from overflowing.
module dcpu16_divstep (
    input  logic [16:0] p_in,
    input  logic [15:0] dvs,
    output logic [15:0] p_out,
    output logic        q_bit
);

    logic [16:0] diff;

    // Subtract when the trial remainder covers the divisor
    always_comb begin
        diff  = p_in - {1'b0, dvs};
        q_bit = (p_in >= {1'b0, dvs});
        p_out = q_bit ? diff[15:0] : p_in[15:0];
    end

endmodule

// File: rtl/dcpu16_divseq.sv
// dcpu16_divseq: multi-cycle DIV/MOD sequencer.
// One quotient bit per enabled cycle; start/busy/done handshake.
module dcpu16_divseq
    import dcpu16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        start,
    input  logic [3:0]  opc,
    input  logic [15:0] regA,
    input  logic [15:0] regB,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [15:0] regR,
    output logic [15:0] regO
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] d_q, d_d;
    logic [15:0] p_q, p_d;
    logic [15:0] dvs_q, dvs_d;
    logic        div_q, div_d;
    logic [15:0] regr_q, regr_d;
    logic [15:0] rego_q, rego_d;

    logic [15:0] step_p;
    logic        step_q;
    logic [31:0] q_nxt;
    logic [5:0]  last_cnt;
    logic        start_ok;
    logic        last;

    dcpu16_divstep u_step (
        .p_in  ({p_q, d_q[31]}),
        .dvs   (dvs_q),
        .p_out (step_p),
        .q_bit (step_q)
    );

    // Quotient bits shift into the vacated dividend LSBs
    always_comb begin
        q_nxt    = {d_q[30:0], step_q};
        last_cnt = div_q ? 6'(DIV_ITER - 1) : 6'(MOD_ITER - 1);
        last     = (cnt_q == last_cnt);
        start_ok = ena && start && !flush && is_divop(opc);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; flush only cancels work in flight
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok)
                    state_d = (regB != 16'h0) ? ST_CALC : ST_DONE;
            end
            ST_CALC: begin
                if (ena && flush)     state_d = ST_IDLE;
                else if (ena && last) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (ena) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decode straight from state
    always_comb begin
        busy = (state_q == ST_CALC);
        done = (state_q == ST_DONE);
        regR = regr_q;
        regO = rego_q;
    end

    // Datapath next values: operand latch, iteration, result write
    always_comb begin
        cnt_d  = cnt_q;
        d_d    = d_q;
        p_d    = p_q;
        dvs_d  = dvs_q;
        div_d  = div_q;
        regr_d = regr_q;
        rego_d = rego_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok && regB != 16'h0) begin
                    d_d   = {regA, 16'h0};
                    dvs_d = regB;
                    div_d = (opc == OPC_DIV);
                    p_d   = 16'h0;
                    cnt_d = 6'd0;
                end else if (start_ok) begin
                    regr_d = 16'h0;
                    if (opc == OPC_DIV) rego_d = 16'h0;
                end
            end
            ST_CALC: begin
                if (ena && !flush) begin
                    p_d   = step_p;
                    d_d   = q_nxt;
                    cnt_d = cnt_q + 6'd1;
                    if (last && div_q) begin
                        regr_d = q_nxt[31:16];
                        rego_d = q_nxt[15:0];
                    end else if (last) begin
                        regr_d = step_p;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; ena freezes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 6'd0;
            d_q    <= 32'h0;
            p_q    <= 16'h0;
            dvs_q  <= 16'h0;
            div_q  <= 1'b0;
            regr_q <= 16'h0;
            rego_q <= 16'h0;
        end else begin
            cnt_q  <= cnt_d;
            d_q    <= d_d;
            p_q    <= p_d;
            dvs_q  <= dvs_d;
            div_q  <= div_d;
            regr_q <= regr_d;
            rego_q <= rego_d;
        end
    end

endmodule

// File: tb/tb_dcpu16_divseq.sv
// tb_dcpu16_divseq: directed checks for the DIV/MOD sequencer.
// Edge 1 is the start-sampling edge; sampling is #1 after posedge.
module tb_dcpu16_divseq;
    import dcpu16_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  opc = 4'h0;
    logic [15:0] regA = 16'h0;
    logic [15:0] regB = 16'h0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] regR;
    logic [15:0] regO;

    int nchk = 0;
    int npass = 0;
    int lat;
    int nb;
    int ndone;

    dcpu16_divseq dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .start (start),
        .opc   (opc),
        .regA  (regA),
        .regB  (regB),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .regR  (regR),
        .regO  (regO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h exp %h", tag, got, exp);
    endtask

    task automatic issue(input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b);
        @(negedge clk);
        @(negedge clk);
        opc = o; regA = a; regB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int l, output int n);
        l = 1;
        n = busy ? 1 : 0;
        while (!done && l < 100) begin
            @(posedge clk); #1;
            l++;
            if (busy) n++;
        end
    endtask

    initial begin
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_regR", 32'(regR), 32'h0);
        chk("rst_regO", 32'(regO), 32'h0);
        @(negedge clk); rst = 1'b1;

        issue(OPC_DIV, 16'h0007, 16'h0002);
        chk("div1_busy_e1", 32'(busy), 32'h1);
        wait_done(lat, nb);
        chk("div1_lat", 32'(lat), 32'd33);
        chk("div1_nbusy", 32'(nb), 32'd32);
        chk("div1_busy_dn", 32'(busy), 32'h0);
        chk("div1_regR", 32'(regR), 32'h0003);
        chk("div1_regO", 32'(regO), 32'h8000);
        @(posedge clk); #1;
        chk("div1_done_1c", 32'(done), 32'h0);

        issue(OPC_DIV, 16'h0001, 16'h0003);
        wait_done(lat, nb);
        chk("div2_regR", 32'(regR), 32'h0000);
        chk("div2_regO", 32'(regO), 32'h5555);

        issue(OPC_DIV, 16'hFFFF, 16'h0001);
        wait_done(lat, nb);
        chk("div3_regR", 32'(regR), 32'hFFFF);
        chk("div3_regO", 32'(regO), 32'h0000);

        issue(4'h2, 16'h0007, 16'h0002);
        repeat (3) begin @(posedge clk); #1; end
        chk("badop_busy", 32'(busy), 32'h0);
        chk("badop_done", 32'(done), 32'h0);

        issue(OPC_DIV, 16'h091A, 16'h8000);
        wait_done(lat, nb);
        chk("pre_regR", 32'(regR), 32'h0000);
        chk("pre_regO", 32'(regO), 32'h1234);

        issue(OPC_MOD, 16'h0064, 16'h0007);
        wait_done(lat, nb);
        chk("mod_lat", 32'(lat), 32'd17);
        chk("mod_nbusy", 32'(nb), 32'd16);
        chk("mod_regR", 32'(regR), 32'h0002);
        chk("mod_regO", 32'(regO), 32'h1234);

        issue(OPC_MOD, 16'h0009, 16'h0000);
        wait_done(lat, nb);
        chk("mod0_lat", 32'(lat), 32'd1);
        chk("mod0_regR", 32'(regR), 32'h0000);
        chk("mod0_regO", 32'(regO), 32'h1234);

        issue(OPC_DIV, 16'h0005, 16'h0000);
        wait_done(lat, nb);
        chk("div0_lat", 32'(lat), 32'd1);
        chk("div0_nbusy", 32'(nb), 32'd0);
        chk("div0_regR", 32'(regR), 32'h0000);
        chk("div0_regO", 32'(regO), 32'h0000);

        issue(OPC_DIV, 16'h0007, 16'h0002);
        lat = 1;
        nb = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            ena = !(lat + 1 >= 5 && lat + 1 <= 9);
            start = (lat + 1 == 10);
            opc = OPC_DIV; regA = 16'hFFFF; regB = 16'h0001;
            @(posedge clk); #1;
            lat++;
            if (busy) nb++;
        end
        ena = 1'b1; start = 1'b0;
        chk("ena_lat", 32'(lat), 32'd38);
        chk("ena_nbusy", 32'(nb), 32'd37);
        chk("ena_regR", 32'(regR), 32'h0003);
        chk("ena_regO", 32'(regO), 32'h8000);
        @(negedge clk); ena = 1'b0;
        @(posedge clk); #1;
        chk("ena_done_hold", 32'(done), 32'h1);
        @(negedge clk); ena = 1'b1;
        @(posedge clk); #1;
        chk("ena_done_rel", 32'(done), 32'h0);

        issue(OPC_DIV, 16'h0007, 16'h0002);
        repeat (11) @(posedge clk);
        #3;
        chk("rst_pre_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_regR", 32'(regR), 32'h0);
        chk("arst_regO", 32'(regO), 32'h0);
        @(negedge clk); rst = 1'b1;

        issue(OPC_DIV, 16'h0007, 16'h0002);
        wait_done(lat, nb);
        chk("fl_pre_regR", 32'(regR), 32'h0003);
        issue(OPC_DIV, 16'hFFFF, 16'h0001);
        repeat (6) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_busy", 32'(busy), 32'h0);
        chk("fl_done", 32'(done), 32'h0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("fl_ndone", 32'(ndone), 32'd0);
        chk("fl_regR", 32'(regR), 32'h0003);
        chk("fl_regO", 32'(regO), 32'h8000);

        @(negedge clk);
        opc = OPC_DIV; regA = 16'h0007; regB = 16'h0000;
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flst_busy", 32'(busy), 32'h0);
        chk("flst_done", 32'(done), 32'h0);
        chk("flst_regR", 32'(regR), 32'h0003);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
